// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes and sequencer state encoding shared by the ALU host sequencer
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SEND_X,
    ST_SEND_Y,
    ST_SEND_Z,
    ST_WAIT,
    ST_RESP
  } seq_state_t;

  // Only division carries a third operand byte (the divisor).
  function automatic logic needs_divisor(input logic [1:0] op);
    return op == OP_DIV;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - clearable up-counter flagging the last allowed cycle of a wait window
module wait_timer #(
  parameter int unsigned MAX_COUNT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int unsigned CW = $clog2(MAX_COUNT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !tc) begin
      count <= count + CW'(1);
    end
  end

  // tc marks the MAX_COUNT-th enabled cycle since the last clear.
  assign tc = enable && (count == CW'(MAX_COUNT - 1));

endmodule

// File: rtl/alu_host_sequencer.sv
// rtl/alu_host_sequencer.sv - sequences one host operation onto a byte-serial ALU and returns its result
import alu_pkg::*;

module alu_host_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_x,
  input  logic [7:0]  req_y,
  input  logic [7:0]  req_z,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_timeout,
  output logic        alu_begin,
  output logic [1:0]  alu_op_code,
  output logic [7:0]  alu_inbus,
  input  logic [7:0]  alu_outbus,
  input  logic        alu_end
);

  seq_state_t state, state_nxt;

  logic [1:0] op_q;
  logic [7:0] x_q, y_q, z_q;
  logic [7:0] h1, h0;
  logic       end_q;
  logic       end_event;
  logic       wait_tc;
  logic       in_wait;

  assign in_wait = (state == ST_WAIT);

  // Only a rising edge of END seen while waiting counts; a level left over from before is ignored.
  assign end_event = in_wait && alu_end && !end_q;

  wait_timer #(
    .MAX_COUNT(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk   (clk),
    .reset (reset),
    .clear (!in_wait),
    .enable(in_wait),
    .tc    (wait_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    alu_begin   = 1'b0;
    alu_op_code = 2'b00;
    alu_inbus   = 8'h00;
    case (state)
      ST_IDLE: begin
        // Held low while reset is asserted so every output reads zero during reset.
        req_ready = reset;
        if (req_valid) begin
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        alu_begin   = 1'b1;
        alu_op_code = op_q;
        state_nxt   = ST_SEND_X;
      end
      ST_SEND_X: begin
        alu_op_code = op_q;
        alu_inbus   = x_q;
        state_nxt   = ST_SEND_Y;
      end
      ST_SEND_Y: begin
        alu_op_code = op_q;
        alu_inbus   = y_q;
        state_nxt   = needs_divisor(op_q) ? ST_SEND_Z : ST_WAIT;
      end
      ST_SEND_Z: begin
        alu_op_code = op_q;
        alu_inbus   = z_q;
        state_nxt   = ST_WAIT;
      end
      ST_WAIT: begin
        alu_op_code = op_q;
        if (end_event || wait_tc) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q        <= 2'b00;
      x_q         <= 8'h00;
      y_q         <= 8'h00;
      z_q         <= 8'h00;
      h1          <= 8'h00;
      h0          <= 8'h00;
      end_q       <= 1'b0;
      rsp_data    <= 16'h0000;
      rsp_timeout <= 1'b0;
    end else begin
      h1    <= h0;
      h0    <= alu_outbus;
      end_q <= alu_end;
      if (state == ST_IDLE && req_valid) begin
        op_q <= req_op;
        x_q  <= req_x;
        y_q  <= req_y;
        z_q  <= req_z;
      end
      // END takes priority over an expiring timer in the same cycle.
      if (end_event) begin
        rsp_data    <= {h1, h0};
        rsp_timeout <= 1'b0;
      end else if (wait_tc) begin
        rsp_data    <= 16'h0000;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_host_sequencer.sv
// tb/tb_alu_host_sequencer.sv - self-checking bench for alu_host_sequencer
module tb_alu_host_sequencer;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_x, req_y, req_z;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_timeout;
  logic        alu_begin;
  logic [1:0]  alu_op_code;
  logic [7:0]  alu_inbus;
  logic [7:0]  alu_outbus;
  logic        alu_end;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  alu_host_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_z      (req_z),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_timeout(rsp_timeout),
    .alu_begin  (alu_begin),
    .alu_op_code(alu_op_code),
    .alu_inbus  (alu_inbus),
    .alu_outbus (alu_outbus),
    .alu_end    (alu_end)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Transaction-level model: an accepted op is described by how many cycles have passed since acceptance.
  logic       m_busy, m_resp, m_to, m_endp;
  int         m_k, m_nb, m_w;
  logic [1:0] m_op;
  logic [7:0] m_b [4];
  logic [7:0] m_h1, m_h0;
  logic [15:0] m_data;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_resp <= 1'b0; m_to <= 1'b0; m_endp <= 1'b0;
      m_k <= 0; m_nb <= 2; m_w <= 0; m_op <= 2'b00;
      m_h1 <= 8'h00; m_h0 <= 8'h00; m_data <= 16'h0000;
    end else begin
      if (!m_busy) begin
        if (req_valid) begin
          m_busy <= 1'b1; m_resp <= 1'b0; m_k <= 1; m_w <= 0; m_op <= req_op;
          m_nb <= (req_op == 2'b11) ? 3 : 2;
          m_b[0] <= req_x; m_b[1] <= req_y; m_b[2] <= req_z;
        end
      end else if (m_resp) begin
        if (rsp_ready) m_busy <= 1'b0;
      end else begin
        if (m_k >= 2 + m_nb) begin
          m_w <= m_w + 1;
          if (alu_end && !m_endp) begin
            m_resp <= 1'b1; m_data <= {m_h1, m_h0}; m_to <= 1'b0;
          end else if (m_w + 1 == TO) begin
            m_resp <= 1'b1; m_data <= 16'h0000; m_to <= 1'b1;
          end
        end
        m_k <= m_k + 1;
      end
      m_h1 <= m_h0; m_h0 <= alu_outbus; m_endp <= alu_end;
    end
  end

  logic       e_ready, e_valid, e_begin, e_send;
  logic [1:0] e_opc;
  logic [7:0] e_in;
  assign e_ready = !m_busy;
  assign e_valid = m_busy && m_resp;
  assign e_begin = m_busy && !m_resp && (m_k == 1);
  assign e_send  = m_busy && !m_resp && (m_k >= 2) && (m_k < 2 + m_nb);
  assign e_opc   = (m_busy && !m_resp) ? m_op : 2'b00;
  assign e_in    = e_send ? m_b[2'(m_k - 2)] : 8'h00;

  always @(negedge clk) begin
    if (reset) begin
      check("req_ready", req_ready, e_ready);
      check("rsp_valid", rsp_valid, e_valid);
      check("alu_begin", alu_begin, e_begin);
      check("alu_op_code", alu_op_code, e_opc);
      check("alu_inbus", alu_inbus, e_in);
      if (e_valid) begin
        check("rsp_data", rsp_data, m_data);
        check("rsp_timeout", rsp_timeout, m_to);
      end
    end
  end

  // end_at: WAIT cycle on which END rises (0 = never); result bytes go out on the two cycles before it.
  task automatic run_op(input string name, input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] z, input logic [7:0] hi, input logic [7:0] lo, input int end_at,
                        input bit stale, input int hold, input logic [15:0] exp_data, input logic exp_to,
                        input int exp_lat);
    int c0, n, nb, last;
    logic [7:0] rec [4];
    nb = (op == 2'b11) ? 3 : 2;
    @(posedge clk); #2;
    req_valid = 1'b1; req_op = op; req_x = x; req_y = y; req_z = z;
    if (stale) alu_end = 1'b1;
    c0 = cyc;
    @(posedge clk); #2;
    req_valid = 1'b0;
    for (int j = 0; j <= nb; j++) begin
      @(negedge clk);
      rec[j] = alu_inbus;
    end
    check({name, "_inbus_start"}, rec[0], 8'h00);
    check({name, "_inbus_x"}, rec[1], x);
    check({name, "_inbus_y"}, rec[2], y);
    if (nb == 3) check({name, "_inbus_z"}, rec[3], z);
    @(posedge clk); #2;
    last = (end_at == 0) ? 0 : end_at + 1;
    for (int w = 1; w <= last; w++) begin
      if (w > 1) begin @(posedge clk); #2; end
      if (stale && w == 1) alu_outbus = 8'hAA;
      if (stale && w == 2) begin alu_end = 1'b0; alu_outbus = 8'hBB; end
      if (w == end_at - 2) alu_outbus = hi;
      if (w == end_at - 1) alu_outbus = lo;
      if (w == end_at) alu_end = 1'b1;
      if (w == end_at + 1) alu_end = 1'b0;
    end
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    check({name, "_rsp_seen"}, rsp_valid, 1'b1);
    check({name, "_data"}, rsp_data, exp_data);
    check({name, "_timeout"}, rsp_timeout, exp_to);
    check({name, "_latency"}, cyc - c0, exp_lat);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #2;
      req_valid = 1'b1; req_op = 2'b01; req_x = 8'hFF; req_y = 8'hFF;
    end
    if (hold > 0) begin
      check({name, "_held_valid"}, rsp_valid, 1'b1);
      check({name, "_held_data"}, rsp_data, exp_data);
      check({name, "_held_ready"}, req_ready, 1'b0);
    end
    rsp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clk); #2;
    rsp_ready = 1'b0;
    check({name, "_back_idle"}, req_ready, 1'b1);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_x = 8'h00; req_y = 8'h00; req_z = 8'h00;
    rsp_ready = 1'b0; alu_outbus = 8'h00; alu_end = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_begin", alu_begin, 1'b0);
    check("rst_inbus", alu_inbus, 8'h00);
    check("rst_data", rsp_data, 16'h0000);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("rel_req_ready", req_ready, 1'b1);

    //     name      op     x      y      z      hi     lo    end  stale hold data       to    lat
    run_op("add",    2'b00, 8'h12, 8'h34, 8'h00, 8'h00, 8'h46, 3,  1'b0, 0,  16'h0046, 1'b0, 7);
    run_op("div",    2'b11, 8'h00, 8'h64, 8'h07, 8'h02, 8'h0E, 3,  1'b0, 0,  16'h020E, 1'b0, 8);
    run_op("mul",    2'b10, 8'h0F, 8'h11, 8'h00, 8'h00, 8'hFF, 3,  1'b0, 0,  16'h00FF, 1'b0, 7);
    run_op("stale",  2'b01, 8'h10, 8'h20, 8'h00, 8'hFF, 8'hF0, 7,  1'b1, 0,  16'hFFF0, 1'b0, 11);
    run_op("tmo",    2'b00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 0,  1'b0, 0,  16'h0000, 1'b1, 20);
    run_op("race",   2'b00, 8'h40, 8'h02, 8'h00, 8'h00, 8'h42, 16, 1'b0, 0,  16'h0042, 1'b0, 20);
    run_op("bp",     2'b10, 8'h03, 8'h04, 8'h00, 8'h00, 8'h0C, 3,  1'b0, 10, 16'h000C, 1'b0, 7);

    // Reset in the middle of an operation.
    @(posedge clk); #2;
    req_valid = 1'b1; req_op = 2'b00; req_x = 8'h05; req_y = 8'h06;
    @(posedge clk); #2;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("mid_send_y_inbus", alu_inbus, 8'h06);
    reset = 1'b0;
    #1;
    check("mid_rst_ready", req_ready, 1'b0);
    check("mid_rst_valid", rsp_valid, 1'b0);
    check("mid_rst_opcode", alu_op_code, 2'b00);
    check("mid_rst_inbus", alu_inbus, 8'h00);
    check("mid_rst_data", rsp_data, 16'h0000);
    @(posedge clk); #2;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rel_ready", req_ready, 1'b1);
    repeat (20) @(negedge clk);
    check("mid_no_rsp", rsp_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_host_sequencer.md
ALU_HOST_SEQUENCER -- requirements
Module: alu_host_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, maximum WAIT-state cycles before the operation is abandoned.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  host presents an operation.
REQ-005 req_ready  output  1  sequencer accepts an operation; high only in IDLE.
REQ-006 req_op  input  2  00 add, 01 sub, 10 mul, 11 div.
REQ-007 req_x / req_y / req_z  input  8 each  operands: add/sub/mul use X,Y; div uses X = dividend high, Y = dividend low, Z = divisor.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  host consumes result.
REQ-010 rsp_data  output  16  {high byte, low byte} of ALU result (div: remainder, quotient).
REQ-011 rsp_timeout  output  1  qualifies rsp_valid; ALU never signalled END.
REQ-012 alu_begin  output  1  to ALU BEGIN.
REQ-013 alu_op_code  output  2  to ALU op_code.
REQ-014 alu_inbus  output  8  to ALU inbus.
REQ-015 alu_outbus  input  8  from ALU outbus.
REQ-016 alu_end  input  1  from ALU END.

Function
REQ-017 States: IDLE, START, SEND_X, SEND_Y, SEND_Z, WAIT, RESP.
REQ-018 IDLE: req_ready=1; on req_valid, latch op and operands, go START; otherwise stay.
REQ-019 START: alu_begin=1 for exactly one cycle; alu_op_code = latched op; go SEND_X.
REQ-020 SEND_X: alu_inbus=X -> SEND_Y; SEND_Y: alu_inbus=Y -> SEND_Z if op=11, else WAIT; SEND_Z: alu_inbus=Z -> WAIT.
REQ-021 alu_inbus SHALL be 8'h00 in every state other than SEND_X/Y/Z.
REQ-022 alu_op_code SHALL hold the latched op from START through WAIT; 2'b00 in IDLE and RESP.
REQ-023 A two-byte history (h1, h0) samples alu_outbus every cycle (h1 <= h0, h0 <= alu_outbus).
REQ-024 end_q registers alu_end every cycle; END event = alu_end & ~end_q, evaluated only in WAIT.
REQ-025 On END event in WAIT: rsp_data <= {h1, h0}, rsp_timeout <= 0, go RESP.
REQ-026 A level-high alu_end already present on WAIT entry SHALL NOT count as an event.
REQ-027 WAIT cycle counter clears on WAIT entry; on reaching TIMEOUT_CYCLES without an event: rsp_data <= 0, rsp_timeout <= 1, go RESP.
REQ-028 An END event in the same cycle as timeout SHALL win (normal result).
REQ-029 RESP: rsp_valid=1, rsp_data/rsp_timeout stable; on rsp_ready, go IDLE next cycle; req_ready stays 0 until then.
REQ-030 Throughput: one operation in flight; minimum IDLE-to-IDLE latency = 4 (5 for div) + ALU cycles + 1.

Reset
REQ-031 reset low asynchronously forces IDLE, req_ready=1 after release, all other outputs 0, history, end_q and counter 0.
REQ-032 Reset mid-operation abandons the operation with no response issued.

Structure
REQ-033 State encodings and op-code constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV) SHALL reside in the shared package alu_pkg.
REQ-034 The WAIT timeout counter SHALL be a sub-module instance, wait_timer (clear, enable, terminal-count output).

Verification
REQ-035 Add: op=00, X=8'h12, Y=8'h34; ALU model pushes 8'h00, 8'h46 then END -> rsp_data=16'h0046, rsp_timeout=0.
REQ-036 Div: op=11, X=8'h00, Y=8'h64, Z=8'h07 -> inbus sequence 00, 64, 07 on three consecutive cycles; model pushes 02, 0E -> rsp_data=16'h020E.
REQ-037 Timeout: TIMEOUT_CYCLES=16, alu_end held low -> rsp_valid with rsp_timeout=1, rsp_data=0, exactly 16 cycles after WAIT entry.
REQ-038 Stale END: alu_end high on WAIT entry, drops, rises 5 cycles later -> capture occurs only on that later rise.
REQ-039 Backpressure: rsp_ready low for 10 cycles -> rsp_valid and rsp_data hold, req_ready=0; new req_valid ignored.
REQ-040 Reset asserted during SEND_Y -> all outputs 0 immediately; after release, req_ready=1 and no rsp_valid.
